// File: rtl/janken_judge_pkg.sv
// Shared definitions for the janken judge: hand codes, FSM states, bus widths.
// Pure declarations; no logic or timing of its own.
package janken_judge_pkg;

  localparam int G_DATA_W = 6;

  typedef enum logic [1:0] {
    HAND_NONE  = 2'b00,
    HAND_GU    = 2'b01,
    HAND_CHOKI = 2'b10,
    HAND_PA    = 2'b11
  } hand_t;

  typedef enum logic [1:0] {
    JJ_IDLE   = 2'b00,
    JJ_REVEAL = 2'b01,
    JJ_JUDGE  = 2'b10,
    JJ_RESULT = 2'b11
  } jj_state_t;

  localparam logic [1:0] PLAYER_NONE = 2'b11;

  // Player 0 sits in the top two bits of the packed hand word.
  function automatic logic [1:0] hand_of(input logic [G_DATA_W-1:0] word,
                                         input logic [1:0] idx);
    logic [1:0] h;
    case (idx)
      2'd0:    h = word[5:4];
      2'd1:    h = word[3:2];
      2'd2:    h = word[1:0];
      default: h = 2'b00;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/janken_rule.sv
// Combinational janken judge over three hands; winners[2] is player0, matching the hand bus order.
// Zero latency; no flow control.
// Unresolvable rounds (nobody valid, one or three shapes) report draw.
module janken_rule
  import janken_judge_pkg::*;
(
  input  logic [1:0] hand0,
  input  logic [1:0] hand1,
  input  logic [1:0] hand2,
  output logic [2:0] winners,
  output logic       draw
);

  logic [2:0] valid;
  logic       has_gu;
  logic       has_choki;
  logic       has_pa;
  logic [1:0] n_valid;
  logic [1:0] n_shape;
  logic [1:0] beat;

  always_comb begin
    valid     = {hand0 != HAND_NONE, hand1 != HAND_NONE, hand2 != HAND_NONE};
    has_gu    = (hand0 == HAND_GU)    || (hand1 == HAND_GU)    || (hand2 == HAND_GU);
    has_choki = (hand0 == HAND_CHOKI) || (hand1 == HAND_CHOKI) || (hand2 == HAND_CHOKI);
    has_pa    = (hand0 == HAND_PA)    || (hand1 == HAND_PA)    || (hand2 == HAND_PA);
    n_valid   = {1'b0, valid[0]} + {1'b0, valid[1]} + {1'b0, valid[2]};
    n_shape   = {1'b0, has_gu} + {1'b0, has_choki} + {1'b0, has_pa};

    // Only meaningful when exactly two shapes are present.
    if (has_gu && has_choki)         beat = HAND_GU;
    else if (has_choki && has_pa)    beat = HAND_CHOKI;
    else                             beat = HAND_PA;

    winners = 3'b000;
    draw    = 1'b0;
    if (n_valid == 2'd0) begin
      draw = 1'b1;
    end else if (n_valid == 2'd1) begin
      winners = valid;
    end else if (n_shape == 2'd2) begin
      winners = {hand0 == beat, hand1 == beat, hand2 == beat} & valid;
    end else begin
      draw = 1'b1;
    end
  end

endmodule

// File: rtl/janken_judge.sv
// Captures a packed 3-player hand word, reveals each hand for REVEAL_CYCLES, then judges and scores.
// done rises 3*REVEAL_CYCLES+1 edges after capture; start while busy is dropped (no backpressure).
// JANKEN_SCORE_EN builds the saturating per-player win counters; otherwise scores are tied to 0.
module janken_judge
  import janken_judge_pkg::*;
#(
  parameter int REVEAL_CYCLES = 50_000_000,
  parameter int SCORE_W       = 4
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                start,
  input  logic [G_DATA_W-1:0] g_data_in,
  output logic                busy,
  output logic [1:0]          p_idx,
  output logic [1:0]          p_hand,
  output logic                done,
  output logic [2:0]          winners,
  output logic                draw,
  output logic [SCORE_W-1:0]  score0,
  output logic [SCORE_W-1:0]  score1,
  output logic [SCORE_W-1:0]  score2
);

  localparam int CNT_W = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REVEAL_CYCLES - 1);

  jj_state_t           state_q;
  jj_state_t           state_nx;
  logic [G_DATA_W-1:0] word_q;
  logic [G_DATA_W-1:0] word_nx;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_nx;
  logic [1:0]          p_idx_nx;
  logic [1:0]          p_hand_nx;
  logic                busy_nx;
  logic                done_nx;
  logic [2:0]          winners_nx;
  logic                draw_nx;
  logic                capture;
  logic [2:0]          rule_winners;
  logic                rule_draw;

  assign capture = start && ((state_q == JJ_IDLE) || (state_q == JJ_RESULT));

  janken_rule u_rule (
    .hand0   (word_q[5:4]),
    .hand1   (word_q[3:2]),
    .hand2   (word_q[1:0]),
    .winners (rule_winners),
    .draw    (rule_draw)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state_q <= JJ_IDLE;
    else       state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      JJ_IDLE:   if (start) state_nx = JJ_REVEAL;
      JJ_REVEAL: if ((cnt_q == '0) && (p_idx == 2'd2)) state_nx = JJ_JUDGE;
      JJ_JUDGE:  state_nx = JJ_RESULT;
      JJ_RESULT: if (start) state_nx = JJ_REVEAL;
      default:   state_nx = JJ_IDLE;
    endcase
  end

  always_comb begin
    word_nx    = capture ? g_data_in : word_q;
    cnt_nx     = cnt_q;
    p_idx_nx   = PLAYER_NONE;
    p_hand_nx  = HAND_NONE;
    winners_nx = winners;
    draw_nx    = draw;
    if (capture) begin
      cnt_nx     = CNT_LOAD;
      p_idx_nx   = 2'd0;
      winners_nx = 3'b000;
      draw_nx    = 1'b0;
    end else if (state_q == JJ_REVEAL) begin
      if (cnt_q == '0) begin
        cnt_nx   = CNT_LOAD;
        p_idx_nx = p_idx + 2'd1;
      end else begin
        cnt_nx   = cnt_q - 1'b1;
        p_idx_nx = p_idx;
      end
    end else if (state_q == JJ_JUDGE) begin
      winners_nx = rule_winners;
      draw_nx    = rule_draw;
    end
    if (state_nx == JJ_REVEAL) begin
      p_hand_nx = hand_of(word_nx, p_idx_nx);
    end else begin
      p_idx_nx = PLAYER_NONE;
    end
    busy_nx = (state_nx == JJ_REVEAL) || (state_nx == JJ_JUDGE);
    done_nx = (state_nx == JJ_RESULT);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      word_q  <= '0;
      cnt_q   <= '0;
      p_idx   <= PLAYER_NONE;
      p_hand  <= HAND_NONE;
      busy    <= 1'b0;
      done    <= 1'b0;
      winners <= 3'b000;
      draw    <= 1'b0;
    end else begin
      word_q  <= word_nx;
      cnt_q   <= cnt_nx;
      p_idx   <= p_idx_nx;
      p_hand  <= p_hand_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      winners <= winners_nx;
      draw    <= draw_nx;
    end
  end

`ifdef JANKEN_SCORE_EN
  logic [SCORE_W-1:0] score_q [3];

  // Scores update on the JUDGE->RESULT edge, together with winners.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < 3; i++) score_q[i] <= '0;
    end else if (state_q == JJ_JUDGE) begin
      for (int i = 0; i < 3; i++) begin
        if (rule_winners[2-i] && (score_q[i] != '1)) score_q[i] <= score_q[i] + 1'b1;
      end
    end
  end

  assign score0 = score_q[0];
  assign score1 = score_q[1];
  assign score2 = score_q[2];
`else
  assign score0 = '0;
  assign score1 = '0;
  assign score2 = '0;
`endif

endmodule

// File: tb/tb_janken_judge.sv
// Bench for janken_judge: directed and random rounds against a rule-level reference model.
// Build with or without JANKEN_SCORE_EN; expected scores follow the same macro.
module tb_janken_judge;

  localparam int R    = 4;
  localparam int SW   = 2;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_;
  logic          start;
  logic [5:0]    g_data_in;
  logic          busy;
  logic [1:0]    p_idx;
  logic [1:0]    p_hand;
  logic          done;
  logic [2:0]    winners;
  logic          draw;
  logic [SW-1:0] score0;
  logic [SW-1:0] score1;
  logic [SW-1:0] score2;

  int nvec = 0;
  int nbad = 0;
  int sc[3];

  always #5 clk = ~clk;

  janken_judge #(.REVEAL_CYCLES(R), .SCORE_W(SW)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .start     (start),
    .g_data_in (g_data_in),
    .busy      (busy),
    .p_idx     (p_idx),
    .p_hand    (p_hand),
    .done      (done),
    .winners   (winners),
    .draw      (draw),
    .score0    (score0),
    .score1    (score1),
    .score2    (score2)
  );

  // a beats b exactly when b is the next shape after a in gu->choki->pa->gu.
  function automatic void ref_judge(input logic [5:0] w, output logic [2:0] win, output logic d);
    int h[3];
    bit seen[4];
    int nvalid = 0;
    int nshape = 0;
    int beat = 0;
    for (int s = 0; s < 4; s++) seen[s] = 0;
    for (int i = 0; i < 3; i++) begin
      h[i] = int'(w[5-2*i -: 2]);
      if (h[i] != 0) begin
        nvalid++;
        if (!seen[h[i]]) nshape++;
        seen[h[i]] = 1;
      end
    end
    win = 3'b000;
    d   = 1'b0;
    if (nvalid == 0) d = 1'b1;
    else if (nvalid == 1) begin
      for (int i = 0; i < 3; i++) if (h[i] != 0) win[2-i] = 1'b1;
    end else if (nshape == 2) begin
      for (int a = 1; a < 4; a++)
        for (int b = 1; b < 4; b++)
          if (seen[a] && seen[b] && (b == (a % 3) + 1)) beat = a;
      for (int i = 0; i < 3; i++) if (h[i] == beat) win[2-i] = 1'b1;
    end else d = 1'b1;
  endfunction

  function automatic int exp_score(input int i);
`ifdef JANKEN_SCORE_EN
    return sc[i];
`else
    return (i < 0) ? 1 : 0;
`endif
  endfunction

  task automatic run_round(input logic [5:0] w, input bit poke);
    logic [2:0] ew;
    logic       ed;
    logic [1:0] eh;
    logic [1:0] ei;
    ref_judge(w, ew, ed);
    @(negedge clk);
    start = 1'b1;
    g_data_in = w;
    @(negedge clk);
    start = 1'b0;
    g_data_in = 6'($urandom);
    for (int k = 0; k < 3 * R; k++) begin
      start = 1'b0;
      ei = 2'(k / R);
      eh = w[5-2*(k/R) -: 2];
      nvec++; if (p_idx !== ei) begin nbad++; $display("FAIL reveal_idx k=%0d got %b want %b", k, p_idx, ei); end
      nvec++; if (p_hand !== eh) begin nbad++; $display("FAIL reveal_hand k=%0d got %b want %b", k, p_hand, eh); end
      nvec++; if (busy !== 1'b1 || done !== 1'b0) begin nbad++; $display("FAIL reveal_flags k=%0d busy=%b done=%b want 1/0", k, busy, done); end
      if (k == 0) begin
        nvec++; if (winners !== 3'b000 || draw !== 1'b0) begin nbad++; $display("FAIL clear_result got w=%b d=%b want 000/0", winners, draw); end
      end
      if (poke && k == R + 1) begin start = 1'b1; g_data_in = ~w; end
      @(negedge clk);
    end
    start = 1'b0;
    nvec++; if (p_idx !== 2'b11 || p_hand !== 2'b00 || busy !== 1'b1 || done !== 1'b0) begin
      nbad++; $display("FAIL judge_cycle got idx=%b hand=%b busy=%b done=%b want 11/00/1/0", p_idx, p_hand, busy, done);
    end
    if (poke) begin start = 1'b1; g_data_in = ~w; end
    for (int i = 0; i < 3; i++) if (ew[2-i] && sc[i] < SMAX) sc[i]++;
    @(negedge clk);
    start = 1'b0;
    nvec++; if (done !== 1'b1 || busy !== 1'b0) begin nbad++; $display("FAIL done_timing w=%b got done=%b busy=%b want 1/0", w, done, busy); end
    nvec++; if (winners !== ew || draw !== ed) begin nbad++; $display("FAIL judge w=%b got w=%b d=%b want w=%b d=%b", w, winners, draw, ew, ed); end
    nvec++; if (int'(score0) != exp_score(0) || int'(score1) != exp_score(1) || int'(score2) != exp_score(2)) begin
      nbad++; $display("FAIL scores got %0d %0d %0d want %0d %0d %0d", score0, score1, score2, exp_score(0), exp_score(1), exp_score(2));
    end
  endtask

  task automatic test_reset;
    rst_ = 1'b0; start = 1'b0; g_data_in = 6'b0;
    for (int i = 0; i < 3; i++) sc[i] = 0;
    repeat (2) @(negedge clk);
    nvec++; if (busy !== 1'b0 || done !== 1'b0 || winners !== 3'b000 || draw !== 1'b0) begin
      nbad++; $display("FAIL reset_flags got busy=%b done=%b w=%b d=%b want 0/0/000/0", busy, done, winners, draw);
    end
    nvec++; if (p_idx !== 2'b11 || p_hand !== 2'b00 || score0 !== '0 || score1 !== '0 || score2 !== '0) begin
      nbad++; $display("FAIL reset_outputs got idx=%b hand=%b s=%0d/%0d/%0d want 11/00/0", p_idx, p_hand, score0, score1, score2);
    end
    rst_ = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    run_round(6'b01_10_10, 1'b0);
    run_round(6'b01_10_11, 1'b0);
    run_round(6'b00_00_11, 1'b0);
    run_round(6'b00_00_00, 1'b0);
  endtask

  task automatic test_hold;
    logic [2:0] w0 = winners;
    logic       d0 = draw;
    repeat (5) @(negedge clk);
    nvec++; if (done !== 1'b1 || winners !== w0 || draw !== d0 || busy !== 1'b0) begin
      nbad++; $display("FAIL result_hold got done=%b w=%b d=%b want 1/%b/%b", done, winners, draw, w0, d0);
    end
  endtask

  task automatic test_start_ignored;
    run_round(6'b11_01_00, 1'b1);
    run_round(6'b10_11_11, 1'b1);
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    start = 1'b1; g_data_in = 6'b01_11_10;
    @(negedge clk);
    start = 1'b0;
    repeat (R + 1) @(negedge clk);
    nvec++; if (p_idx !== 2'd1) begin nbad++; $display("FAIL pre_reset_idx got %b want 01", p_idx); end
    #2 rst_ = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) sc[i] = 0;
    nvec++; if (busy !== 1'b0 || p_idx !== 2'b11 || p_hand !== 2'b00 || done !== 1'b0) begin
      nbad++; $display("FAIL mid_reset got busy=%b idx=%b hand=%b done=%b want 0/11/00/0", busy, p_idx, p_hand, done);
    end
    nvec++; if (score0 !== '0 || score1 !== '0 || score2 !== '0) begin
      nbad++; $display("FAIL mid_reset_scores got %0d %0d %0d want 0", score0, score1, score2);
    end
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_saturation;
    for (int r = 0; r < 5; r++) run_round(6'b10_10_01, 1'b0);
  endtask

  task automatic test_random;
    for (int r = 0; r < 30; r++) run_round(6'($urandom), r[0]);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_hold;
    test_start_ignored;
    test_mid_reset;
    test_saturation;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
